// File: rtl/bingo_disp_pkg.sv
// Shared colours, line-index encoding and elaboration helpers for the Bingo
// board renderer.
package bingo_disp_pkg;

  localparam logic [11:0] FRAME_COLOR  = 12'h732;
  localparam logic [11:0] CIRCLE_COLOR = 12'hc22;
  localparam logic [11:0] LINE_COLOR   = 12'hfd0;
  localparam logic [11:0] CURSOR_COLOR = 12'h0ff;

  // line vector layout: rows [n-1:0], columns [2n-1:n], then both diagonals
  function automatic int line_row0(input int n);
    return 0;
  endfunction

  function automatic int line_col0(input int n);
    return n;
  endfunction

  function automatic int line_diag(input int n);
    return 2 * n;
  endfunction

  function automatic int line_anti(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int abs_i(input int a);
    return (a < 0) ? -a : a;
  endfunction

endpackage

// File: rtl/bingo_frame_sync.sv
// Frame-start detection, per-frame shadow copies of the board state, and the
// cursor blink counter.
module bingo_frame_sync
  import bingo_disp_pkg::*;
#(
  parameter int N            = 5,
  parameter int VAL_W        = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic [N*N*VAL_W-1:0]   map,
  input  logic [N*N-1:0]         circle,
  input  logic [2*N+1:0]         line,
  input  logic [2:0]             cursor_x,
  input  logic [2:0]             cursor_y,
  input  logic                   cursor_en,
  output logic                   frame_start,
  output logic                   armed,
  output logic [N*N*VAL_W-1:0]   map_sh,
  output logic [N*N-1:0]         circle_sh,
  output logic [2*N+1:0]         line_sh,
  output logic [2:0]             cur_x_sh,
  output logic [2:0]             cur_y_sh,
  output logic                   cur_en_sh,
  output logic                   blink_sh
);

  localparam int CW = clog2(BLINK_FRAMES) + 1;

  logic [CW-1:0] frame_cnt;
  logic          blink_on;

  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // blink_sh holds the phase in force before this frame's toggle, so a phase
  // lasts exactly BLINK_FRAMES frames counted from reset
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      blink_sh  <= 1'b0;
      armed     <= 1'b0;
      map_sh    <= '0;
      circle_sh <= '0;
      line_sh   <= '0;
      cur_x_sh  <= '0;
      cur_y_sh  <= '0;
      cur_en_sh <= 1'b0;
    end else if (frame_start) begin
      armed     <= 1'b1;
      map_sh    <= map;
      circle_sh <= circle;
      line_sh   <= line;
      cur_x_sh  <= cursor_x;
      cur_y_sh  <= cursor_y;
      cur_en_sh <= cursor_en;
      blink_sh  <= blink_on;
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bingo_board_renderer.sv
// Three-stage pixel pipeline: geometry + ROM addressing, hit detection,
// colour composition for an N x N Bingo board.
module bingo_board_renderer
  import bingo_disp_pkg::*;
#(
  parameter int N            = 5,
  parameter int CELL         = 64,
  parameter int ORIGIN_X     = 160,
  parameter int ORIGIN_Y     = 80,
  parameter int FRAME_W      = 2,
  parameter int VAL_W        = 5,
  parameter int R_IN         = 24,
  parameter int R_OUT        = 28,
  parameter int LINE_W       = 6,
  parameter int BLINK_FRAMES = 30,
  parameter int BACK_W       = 160,
  parameter int BACK_H       = 120,
  localparam int LC          = clog2(CELL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic                   valid_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [N*N*VAL_W-1:0]   map,
  input  logic [N*N-1:0]         circle,
  input  logic [2*N+1:0]         line,
  input  logic [2:0]             cursor_x,
  input  logic [2:0]             cursor_y,
  input  logic                   cursor_en,
  output logic [VAL_W+2*LC-1:0]  sprite_addr,
  output logic [16:0]            back_addr,
  input  logic [11:0]            sprite_data,
  input  logic [11:0]            back_data,
  output logic [11:0]            pixel,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int BW = N * CELL;

  logic                 frame_start, armed, cur_en_sh, blink_sh;
  logic [N*N*VAL_W-1:0] map_sh;
  logic [N*N-1:0]       circle_sh;
  logic [2*N+1:0]       line_sh;
  logic [2:0]           cur_x_sh, cur_y_sh;

  bingo_frame_sync #(.N(N), .VAL_W(VAL_W), .BLINK_FRAMES(BLINK_FRAMES)) u_sync (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .map(map), .circle(circle), .line(line),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .frame_start(frame_start), .armed(armed),
    .map_sh(map_sh), .circle_sh(circle_sh), .line_sh(line_sh),
    .cur_x_sh(cur_x_sh), .cur_y_sh(cur_y_sh), .cur_en_sh(cur_en_sh),
    .blink_sh(blink_sh)
  );

  logic [1:0] vld_pipe, hs_pipe, vs_pipe;

  // ---- S1: geometry and ROM addresses ----
  logic signed [11:0]   gx0, gy0, gx1, gy1;
  logic                 inb0, inf0, inb1, inf1;
  logic [N*N*VAL_W-1:0] map_cur;
  logic [VAL_W-1:0]     val0;
  int                   ba0;

  always_comb begin
    gx0  = $signed({2'b00, h_cnt}) - 12'(ORIGIN_X);
    gy0  = $signed({2'b00, v_cnt}) - 12'(ORIGIN_Y);
    inb0 = (gx0 >= 0) && (gx0 < BW) && (gy0 >= 0) && (gy0 < BW);
    inf0 = !inb0 && (gx0 >= -FRAME_W) && (gx0 < BW + FRAME_W) &&
           (gy0 >= -FRAME_W) && (gy0 < BW + FRAME_W);
    // the frame_start pixel must already see the incoming map
    map_cur = frame_start ? map : map_sh;
    val0 = '0;
    for (int i = 0; i < N * N; i++)
      if (inb0 && i == int'(gx0[LC +: 3]) + int'(gy0[LC +: 3]) * N)
        val0 = map_cur[i*VAL_W +: VAL_W];
    if (inb0) ba0 = int'(gx0 >>> 1) + int'(gy0 >>> 1) * (BW / 2);
    else      ba0 = (int'(v_cnt) % BACK_H) * BACK_W + int'(h_cnt) % BACK_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gx1 <= '0; gy1 <= '0; inb1 <= 1'b0; inf1 <= 1'b0;
      sprite_addr <= '0; back_addr <= '0;
      vld_pipe[0] <= 1'b0; hs_pipe[0] <= 1'b0; vs_pipe[0] <= 1'b0;
    end else begin
      gx1 <= gx0; gy1 <= gy0; inb1 <= inb0; inf1 <= inf0;
      sprite_addr <= {val0, gy0[LC-1:0], gx0[LC-1:0]};
      back_addr   <= 17'(ba0);
      vld_pipe[0] <= valid_in & (armed | frame_start);
      hs_pipe[0]  <= hsync_in;
      vs_pipe[0]  <= vsync_in;
    end
  end

  // ---- S2: hit flags ----
  int   x, y, lx, ly, cx, cy, dx, dy, d2;
  logic ring_c, line_c, cur_c, edge_c;
  logic ring2, line2, cur2, inb2, inf2;

  always_comb begin
    x  = int'(gx1);
    y  = int'(gy1);
    lx = int'(gx1[LC-1:0]);
    ly = int'(gy1[LC-1:0]);
    cx = int'(gx1[LC +: 3]);
    cy = int'(gy1[LC +: 3]);
    dx = lx - CELL / 2;
    dy = ly - CELL / 2;
    d2 = dx * dx + dy * dy;
    ring_c = 1'b0;
    for (int i = 0; i < N * N; i++)
      if (i == cx + cy * N && circle_sh[i]) ring_c = 1'b1;
    ring_c = ring_c && inb1 && (d2 >= R_IN * R_IN) && (d2 < R_OUT * R_OUT);
    line_c = 1'b0;
    for (int r = 0; r < N; r++) begin
      if (line_sh[line_row0(N) + r] && abs_i(y - (r * CELL + CELL / 2)) < LINE_W / 2)
        line_c = 1'b1;
      if (line_sh[line_col0(N) + r] && abs_i(x - (r * CELL + CELL / 2)) < LINE_W / 2)
        line_c = 1'b1;
    end
    if (line_sh[line_diag(N)] && abs_i(x - y) < LINE_W) line_c = 1'b1;
    if (line_sh[line_anti(N)] && abs_i(x + y - (BW - 1)) < LINE_W) line_c = 1'b1;
    line_c = line_c && inb1;
    edge_c = (lx < 2) || (lx >= CELL - 2) || (ly < 2) || (ly >= CELL - 2);
    cur_c  = inb1 && cur_en_sh && blink_sh && edge_c &&
             int'(cur_x_sh) == cx && int'(cur_y_sh) == cy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring2 <= 1'b0; line2 <= 1'b0; cur2 <= 1'b0; inb2 <= 1'b0; inf2 <= 1'b0;
      vld_pipe[1] <= 1'b0; hs_pipe[1] <= 1'b0; vs_pipe[1] <= 1'b0;
    end else begin
      ring2 <= ring_c; line2 <= line_c; cur2 <= cur_c; inb2 <= inb1; inf2 <= inf1;
      vld_pipe[1] <= vld_pipe[0]; hs_pipe[1] <= hs_pipe[0]; vs_pipe[1] <= vs_pipe[0];
    end
  end

  // ---- S3: compose ----
  logic [11:0] pix_c;

  always_comb begin
    pix_c = back_data;
    if (!vld_pipe[1])             pix_c = 12'h000;
    else if (inb2) begin
      if (line2)                  pix_c = LINE_COLOR;
      else if (ring2)             pix_c = CIRCLE_COLOR;
      else if (cur2)              pix_c = CURSOR_COLOR;
      else if (sprite_data != '0) pix_c = sprite_data;
    end else if (inf2)            pix_c = FRAME_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel <= '0; hsync <= 1'b0; vsync <= 1'b0;
    end else begin
      pixel <= pix_c; hsync <= hs_pipe[1]; vsync <= vs_pipe[1];
    end
  end

endmodule

// File: tb/tb_bingo_board_renderer.sv
// Directed bench for bingo_board_renderer: N=5, CELL=64, BLINK_FRAMES=2,
// with one-cycle ROM models on sprite_addr/back_addr.
module tb_bingo_board_renderer;

  localparam int N = 5;
  localparam int VAL_W = 5;
  localparam int LC = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [9:0]           h_cnt = '0, v_cnt = '0;
  logic                 valid_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [N*N*VAL_W-1:0] map = '0;
  logic [N*N-1:0]       circle = '0;
  logic [2*N+1:0]       line = '0;
  logic [2:0]           cursor_x = '0, cursor_y = '0;
  logic                 cursor_en = 1'b0;
  logic [VAL_W+2*LC-1:0] sprite_addr;
  logic [16:0]          back_addr;
  logic [11:0]          sprite_data = '0, back_data = '0;
  logic [11:0]          pixel;
  logic                 hsync, vsync;

  int n_chk = 0, n_pass = 0;

  bingo_board_renderer #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .map(map), .circle(circle), .line(line),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .sprite_addr(sprite_addr), .back_addr(back_addr),
    .sprite_data(sprite_data), .back_data(back_data),
    .pixel(pixel), .hsync(hsync), .vsync(vsync)
  );

  always #20 clk = ~clk;

  // ROM models: sprite opaque for any nonzero cell value
  always @(posedge clk) begin
    sprite_data <= (sprite_addr[VAL_W+2*LC-1 -: VAL_W] != '0) ? 12'h5a5 : 12'h000;
    back_data   <= back_addr[11:0] ^ 12'h800;
  end

  function automatic logic [11:0] exp_back(input int h, input int v);
    int gx, gy, a;
    gx = h - 160;
    gy = v - 80;
    if (gx >= 0 && gx < 320 && gy >= 0 && gy < 320) a = gx / 2 + (gy / 2) * 160;
    else a = (v % 120) * 160 + h % 160;
    return 12'(a) ^ 12'h800;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic vld,
                       input logic [11:0] exp);
    h_cnt = 10'(h); v_cnt = 10'(v); valid_in = vld; hsync_in = 1'b1; vsync_in = 1'b0;
    @(posedge clk); #1;
    h_cnt = 10'd799; v_cnt = 10'd520; valid_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk(tag, 32'(pixel), 32'(exp));
    chk({tag, "_sync"}, {30'd0, hsync, vsync}, 32'd2);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    h_cnt = 10'd799; v_cnt = 10'd520;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_addr", {15'd0, back_addr}, 32'd0);
    chk("rst_saddr", 32'(sprite_addr), 32'd0);
    chk("rst_sync", {30'd0, hsync, vsync}, 32'd0);
    rst = 1'b0;

    // frame A: all state zero
    probe("unarmed", 200, 100, 1'b1, 12'h000);
    probe("fsA", 0, 0, 1'b1, 12'h800);
    probe("boardA", 200, 100, 1'b1, exp_back(200, 100));
    probe("frameL1", 159, 100, 1'b1, 12'h732);
    probe("frameL2", 158, 100, 1'b1, 12'h732);
    probe("outL", 157, 100, 1'b1, exp_back(157, 100));
    probe("frameR", 481, 100, 1'b1, 12'h732);
    probe("outR", 482, 100, 1'b1, exp_back(482, 100));
    probe("frameB", 200, 401, 1'b1, 12'h732);
    probe("mask_in", 200, 100, 1'b0, 12'h000);
    probe("mask_off", 700, 100, 1'b0, 12'h000);

    // frame B: ring + sprite in cell 0
    map[4:0] = 5'd3;
    circle[0] = 1'b1;
    probe("fsB", 0, 0, 1'b1, 12'h800);
    probe("ring26", 218, 112, 1'b1, 12'hc22);
    probe("ring_in", 216, 112, 1'b1, 12'hc22);
    probe("ring_out", 220, 112, 1'b1, 12'h5a5);
    probe("ring_hole", 215, 112, 1'b1, 12'h5a5);
    probe("sprite_ctr", 192, 112, 1'b1, 12'h5a5);
    probe("no_circ", 282, 112, 1'b1, exp_back(282, 112));
    // line rises mid-frame: not visible yet
    line[N] = 1'b1;
    probe("tear", 192, 150, 1'b1, exp_back(192, 150));

    // frame C: column-0 strike
    probe("fsC", 0, 0, 1'b1, 12'h800);
    for (int k = 0; k < N; k++) probe("col0", 192, 80 + k * 64 + 7, 1'b1, 12'hfd0);
    probe("col_off", 200, 151, 1'b1, exp_back(200, 151));
    probe("col_edge", 194, 151, 1'b1, 12'hfd0);
    probe("col_past", 195, 151, 1'b1, exp_back(195, 151));
    probe("col_frame", 192, 79, 1'b1, 12'h732);

    // reset during board scan
    h_cnt = 10'd192; v_cnt = 10'd100; valid_in = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pix", 32'(pixel), 32'd0);
    chk("mid_rst_addr", {15'd0, back_addr}, 32'd0);
    rst = 1'b0;
    probe("post_rst", 192, 100, 1'b1, 12'h000);
    probe("fsR", 0, 0, 1'b1, 12'h800);
    probe("post_fs", 192, 100, 1'b1, 12'hfd0);

    // cursor blink, counted from a fresh reset
    map = '0; circle = '0; line = '0;
    cursor_x = 3'd2; cursor_y = 3'd3; cursor_en = 1'b1;
    pulse_rst();
    for (int f = 0; f < 5; f++) begin
      logic on;
      on = (f < 2) || (f >= 4);
      probe("fs_blink", 0, 0, 1'b1, 12'h800);
      probe("cur_left", 288, 282, 1'b1, on ? 12'h0ff : exp_back(288, 282));
      probe("cur_right", 351, 282, 1'b1, on ? 12'h0ff : exp_back(351, 282));
      probe("cur_inner", 298, 282, 1'b1, exp_back(298, 282));
    end
    cursor_x = 3'd7;
    probe("fs5", 0, 0, 1'b1, 12'h800);
    probe("cur_gone", 288, 282, 1'b1, exp_back(288, 282));
    probe("cur_oob", 160, 80, 1'b1, exp_back(160, 80));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
